uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side byte buffer placed directly upstream of the UART transmitter. It accepts bytes from the host at full clock rate, stores them in a circular FIFO, and feeds them one at a time into the transmitter's xmitH/xmit_dataH/xmit_doneH handshake. Each new byte is launched only after the previous byte's stop bit has completed. The block lets software burst up to DEPTH bytes without polling per-byte completion.

## Interface
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries); legal range 2..8
- LAUNCH_TIMEOUT, 8, cycles to wait for the transmitter to leave idle after a launch
- sys_clk  in  1  clock; all logic on rising edge
- sys_rst_l  in  1  reset, asynchronous, active-low
- wr_en  in  1  host write strobe; one byte per cycle while high
- wr_data  in  8  host byte, sampled when wr_en=1
- full  out  1  FIFO holds DEPTH entries; registered
- empty  out  1  FIFO holds 0 entries; registered
- overflow  out  1  sticky; a write was attempted while full
- tx_err  out  1  sticky; the launch timeout expired
- clr_status  in  1  synchronous clear of overflow and tx_err
- xmitH  out  1  one-cycle launch pulse to the transmitter
- xmit_dataH  out  8  byte to transmit; stable from launch until the next launch
- xmit_doneH  in  1  transmitter idle/done flag; high while the transmitter is idle
- level  out  DEPTH_LOG2+1  occupancy; present only with UART_TXF_LEVEL_EN

## Operation
- Storage: DEPTH x 8 array with wr_ptr and rd_ptr of width DEPTH_LOG2 that wrap modulo DEPTH, plus count of width DEPTH_LOG2+1.
- Write: wr_en=1 and full=0 stores wr_data at wr_ptr, then increments wr_ptr and count.
- Write while full:
  - The byte is dropped and overflow is set.
  - full is evaluated from the registered count, so a write in the same cycle as a pop while full is also rejected.
- Feeder FSM, states IDLE, WAIT_BUSY, WAIT_DONE:
  - IDLE: if count != 0 and xmit_doneH = 1:
    - register xmitH = 1 and xmit_dataH = mem[rd_ptr];
    - pop (rd_ptr++, count--);
    - go to WAIT_BUSY.
  - WAIT_BUSY: xmitH returns to 0. Wait for xmit_doneH = 0, then go to WAIT_DONE. If LAUNCH_TIMEOUT cycles pass without that, set tx_err and return to IDLE; the byte counts as consumed.
  - WAIT_DONE: wait for xmit_doneH = 1, then go to IDLE.
- Simultaneous write and pop when not full: both take effect and count is unchanged.
- clr_status has lower priority than a same-cycle set event, so the flag stays set.
- Reset at any time:
  - empties the FIFO and zeroes the pointers;
  - FSM goes to IDLE;
  - a transfer in progress is abandoned (the transmitter shares the reset).
- Unreachable FSM encodings recover to IDLE.

## Timing
- Reset values: xmitH 0, xmit_dataH 8'h00, full 0, empty 1, overflow 0, tx_err 0, level 0.
- Write latency: empty and full update on the edge that samples wr_en.
- Launch latency: a write sampled at edge N into an empty FIFO, with the transmitter idle, gives xmitH high for exactly the cycle after edge N+1.
- xmitH is never high for two consecutive cycles. At least one full WAIT_BUSY/WAIT_DONE round trip separates launches.
- xmit_dataH is registered and changes only on a launch edge.

## Configuration
- UART_TXF_LEVEL_EN defined: the level port exists and carries count. Registered, it updates on the same edge as full and empty.
- UART_TXF_LEVEL_EN undefined: the level port and its logic are absent; everything else is identical.

## Structure
- Package uart_pkg:
  - feeder state typedef (IDLE/WAIT_BUSY/WAIT_DONE, 2-bit encoding);
  - default DEPTH_LOG2 and LAUNCH_TIMEOUT constants;
  - byte width constant 8.
- Sub-module uart_fifo_mem: array, pointers, count, full/empty/overflow.
- Top level: feeder FSM, timeout counter, tx_err, output registers.

## Test plan
- Reset with wr_en=1 held -> all outputs at reset values; no write accepted while sys_rst_l=0.
- Write 8'hA5 into an empty FIFO with xmit_doneH=1 -> xmitH one-cycle pulse two edges later, xmit_dataH=8'hA5, empty=1 after the pop.
- Burst of 17 writes with DEPTH_LOG2=4 and xmit_doneH held 0 -> full=1 after 16, 17th dropped, overflow=1; clr_status clears overflow.
- Model the transmitter dropping xmit_doneH 3 cycles after launch and raising it 40 cycles later, with bytes 01,02,03 queued -> three launches in order, each only after xmit_doneH returns high.
- Keep xmit_doneH high after a launch -> tx_err=1 after 8 cycles, FSM back in IDLE, next byte launched.
- Assert reset mid-WAIT_DONE with 5 bytes queued -> empty=1, xmitH=0; after release, no launch until a new write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-side FIFO slice.
package uart_pkg;

  localparam int unsigned BYTE_W                 = 8;
  localparam int unsigned DEFAULT_DEPTH_LOG2     = 4;
  localparam int unsigned DEFAULT_LAUNCH_TIMEOUT = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitBusy = 2'd1,
    StWaitDone = 2'd2
  } feed_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular byte FIFO with registered full/empty flags and sticky overflow.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_l,
  input  logic                  wr_en,
  input  logic [BYTE_W-1:0]     wr_data,
  input  logic                  pop,
  input  logic                  clr_status,
  output logic [BYTE_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  logic [BYTE_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q, overflow_q;
  logic                  wr_ok, pop_ok;

  // Full comes from the registered count, so a write during a pop-while-full is still dropped.
  assign wr_ok  = wr_en & ~full_q;
  assign pop_ok = pop & (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (wr_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (!wr_ok && pop_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == (DEPTH_LOG2 + 1)'(DEPTH));
      empty_q <= (count_d == '0);
      if (wr_en && full_q) begin
        overflow_q <= 1'b1;
      end else if (clr_status) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding a UART transmitter through the xmitH/xmit_doneH handshake.
// Optional occupancy port enabled by defining UART_TXF_LEVEL_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2     = DEFAULT_DEPTH_LOG2,
  parameter int unsigned LAUNCH_TIMEOUT = DEFAULT_LAUNCH_TIMEOUT
) (
  input  logic                sys_clk,
  input  logic                sys_rst_l,
  input  logic                wr_en,
  input  logic [BYTE_W-1:0]   wr_data,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                tx_err,
  input  logic                clr_status,
  output logic                xmitH,
  output logic [BYTE_W-1:0]   xmit_dataH,
  input  logic                xmit_doneH
`ifdef UART_TXF_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0] level
`endif
);

  localparam int unsigned TMR_W = $clog2(LAUNCH_TIMEOUT) + 1;

  feed_state_e         state_q;
  logic [TMR_W-1:0]    timer_q;
  logic                xmit_q, tx_err_q;
  logic [BYTE_W-1:0]   xmit_data_q;
  logic [BYTE_W-1:0]   rd_data;
  logic [DEPTH_LOG2:0] count;
  logic                pop;

  assign pop = (state_q == StIdle) && (count != '0) && xmit_doneH;

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .pop        (pop),
    .clr_status (clr_status),
    .rd_data    (rd_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      xmit_q      <= 1'b0;
      xmit_data_q <= '0;
      tx_err_q    <= 1'b0;
    end else begin
      xmit_q <= 1'b0;
      // Clear first so a same-cycle timeout below wins.
      if (clr_status) begin
        tx_err_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (pop) begin
            xmit_q      <= 1'b1;
            xmit_data_q <= rd_data;
            timer_q     <= '0;
            state_q     <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (!xmit_doneH) begin
            state_q <= StWaitDone;
          end else if (timer_q == TMR_W'(LAUNCH_TIMEOUT - 1)) begin
            tx_err_q <= 1'b1;
            state_q  <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (xmit_doneH) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign xmitH      = xmit_q;
  assign xmit_dataH = xmit_data_q;
  assign tx_err     = tx_err_q;

`ifdef UART_TXF_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, scoreboard and a simple transmitter model.
module tb_uart_tx_fifo;

  localparam int unsigned DL = 4;

  logic        sys_clk = 1'b0;
  logic        sys_rst_l = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'h00;
  logic        clr_status = 1'b0;
  logic        tb_done = 1'b1;
  logic        model_en = 1'b0;
  logic        model_done = 1'b1;
  logic        xmit_doneH;
  logic        full, empty, overflow, tx_err, xmitH;
  logic [7:0]  xmit_dataH;
`ifdef UART_TXF_LEVEL_EN
  logic [DL:0] level;
`endif

  assign xmit_doneH = model_en ? model_done : tb_done;

  uart_tx_fifo #(
    .DEPTH_LOG2     (DL),
    .LAUNCH_TIMEOUT (8)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .tx_err     (tx_err),
    .clr_status (clr_status),
    .xmitH      (xmitH),
    .xmit_dataH (xmit_dataH),
    .xmit_doneH (xmit_doneH)
`ifdef UART_TXF_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int         total = 0;
  int         bad = 0;
  int         cycle = 0;
  int         launches = 0;
  logic [7:0] sb [$];
  int         launch_cyc [$];

  typedef struct {
    logic        we;
    logic [7:0]  d;
    logic        clr;
    logic        acc;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
    logic [DL:0] e_lvl;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_launches(input int target, input int budget, input string name);
    int n = 0;
    while (launches < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(launches >= target), 1);
  endtask

  initial forever begin
    @(posedge sys_clk);
    cycle++;
  end

  // Transmitter: drops done 3 cycles after a launch, raises it again 40 cycles later.
  initial begin
    int mcnt = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (!sys_rst_l) begin
        mcnt = 0;
        model_done = 1'b1;
      end else if (model_en && xmitH) begin
        mcnt = 1;
      end else if (mcnt != 0) begin
        mcnt++;
        if (mcnt == 4) model_done = 1'b0;
        if (mcnt == 44) begin
          model_done = 1'b1;
          mcnt = 0;
        end
      end
    end
  end

  // Launch monitor: pops the scoreboard on every xmitH pulse.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_l) begin
        prev = 1'b0;
      end else begin
        if (xmitH) begin
          launches++;
          launch_cyc.push_back(cycle);
          check("xmit_back_to_back", 32'(prev), 0);
          check("done_at_launch", 32'(xmit_doneH), 1);
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_launch: got data %0h want no launch", xmit_dataH);
          end else begin
            check("launch_data", 32'(xmit_dataH), 32'(sb.pop_front()));
          end
        end
        prev = xmitH;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    for (int i = 0; i < 17; i++) begin
      vecs[i] = '{we: 1'b1, d: 8'(8'h40 + i), clr: 1'b0, acc: (i < 16), e_full: (i >= 15),
                  e_empty: 1'b0, e_ovf: (i == 16), e_lvl: (i < 16) ? 5'(i + 1) : 5'd16};
    end
    vecs[17] = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd16};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd16};

    // Reset with a write held: nothing may be accepted.
    wr_en = 1'b1;
    wr_data = 8'h55;
    repeat (3) tick();
    check("rst_xmitH", 32'(xmitH), 0);
    check("rst_xmit_data", 32'(xmit_dataH), 0);
    check("rst_full", 32'(full), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_tx_err", 32'(tx_err), 0);
`ifdef UART_TXF_LEVEL_EN
    check("rst_level", 32'(level), 0);
`endif
    wr_en = 1'b0;
    tick();
    sys_rst_l = 1'b1;
    repeat (3) tick();
    check("post_rst_empty", 32'(empty), 1);
    check("post_rst_no_launch", 32'(launches), 0);

    // Single byte, transmitter idle, then launch timeout.
    wr_en = 1'b1;
    wr_data = 8'hA5;
    sb.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("a5_empty_after_write", 32'(empty), 0);
    check("a5_no_early_launch", 32'(xmitH), 0);
    tick();
    check("a5_launch", 32'(xmitH), 1);
    check("a5_data", 32'(xmit_dataH), 32'h A5);
    check("a5_empty_after_pop", 32'(empty), 1);
    tick();
    check("a5_pulse_one_cycle", 32'(xmitH), 0);
    repeat (6) tick();
    check("timeout_not_yet", 32'(tx_err), 0);
    tick();
    check("timeout_tx_err", 32'(tx_err), 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("tx_err_cleared", 32'(tx_err), 0);

    // Two bytes queued; second must launch straight after the first times out.
    wr_en = 1'b1;
    wr_data = 8'h11;
    sb.push_back(8'h11);
    tick();
    check("q2_empty", 32'(empty), 0);
    wr_data = 8'h22;
    sb.push_back(8'h22);
    tick();
    wr_en = 1'b0;
    check("q2_first_launch", 32'(xmitH), 1);
    check("q2_not_empty", 32'(empty), 0);
    repeat (7) tick();
    check("q2_timeout_not_yet", 32'(tx_err), 0);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("q2_set_beats_clear", 32'(tx_err), 1);
    check("q2_idle_gap", 32'(xmitH), 0);
    tick();
    check("q2_second_launch", 32'(xmitH), 1);
    check("q2_second_data", 32'(xmit_dataH), 32'h22);
    check("q2_empty_after", 32'(empty), 1);
    repeat (9) tick();
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("q2_tx_err_cleared", 32'(tx_err), 0);

    // Burst into a stalled transmitter from the vector table.
    tb_done = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      wr_en = vecs[i].we;
      wr_data = vecs[i].d;
      clr_status = vecs[i].clr;
      if (vecs[i].acc) sb.push_back(vecs[i].d);
      tick();
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      check($sformatf("vec%0d_xmitH", i), 32'(xmitH), 0);
`ifdef UART_TXF_LEVEL_EN
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
`endif
    end
    wr_en = 1'b0;
    clr_status = 1'b0;

    // Drain the full FIFO through the transmitter model.
    model_en = 1'b1;
    base = launches;
    wait_launches(base + 16, 16 * 46 + 20, "drain_16");
    check("drain_sb_empty", 32'(sb.size()), 0);
    repeat (50) tick();
    check("drain_empty", 32'(empty), 1);
    check("drain_full", 32'(full), 0);

    // Three bytes with handshake pacing.
    launch_cyc.delete();
    base = launches;
    wr_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr_data = 8'(i);
      sb.push_back(8'(i));
      tick();
    end
    wr_en = 1'b0;
    wait_launches(base + 3, 200, "paced_3");
    if (launch_cyc.size() >= 3) begin
      check("paced_gap_1", 32'(launch_cyc[1] - launch_cyc[0]), 45);
      check("paced_gap_2", 32'(launch_cyc[2] - launch_cyc[1]), 45);
    end else begin
      check("paced_launch_count", 32'(launch_cyc.size()), 3);
    end
    repeat (50) tick();

    // Reset in the middle of WAIT_DONE with bytes still queued.
    base = launches;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'(8'hC0 + i);
      sb.push_back(8'(8'hC0 + i));
      tick();
    end
    wr_en = 1'b0;
    wait_launches(base + 1, 20, "rst_mid_first_launch");
    repeat (10) tick();
    check("rst_mid_in_wait_done", 32'(xmit_doneH), 0);
    sys_rst_l = 1'b0;
    #1;
    check("rst_mid_empty", 32'(empty), 1);
    check("rst_mid_xmitH", 32'(xmitH), 0);
    check("rst_mid_full", 32'(full), 0);
    sb.delete();
    repeat (2) tick();
    sys_rst_l = 1'b1;
    base = launches;
    repeat (60) tick();
    check("rst_mid_no_launch", 32'(launches), 32'(base));
    check("rst_mid_still_empty", 32'(empty), 1);
    wr_en = 1'b1;
    wr_data = 8'h77;
    sb.push_back(8'h77);
    tick();
    wr_en = 1'b0;
    wait_launches(base + 1, 5, "rst_mid_new_launch");
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
